// File: rtl/bcd7_scan.sv
// Multiplexed NDIG-digit common-cathode 7-segment driver with per-frame BCD snapshot.
// Optional leading-zero blanking is built when BCD7_SCAN_LZB_EN is defined.
`timescale 1ns/1ps

module bcd7_scan #(
   parameter int NDIG     = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              e,
   input  logic [4*NDIG-1:0] x,
   input  logic [NDIG-1:0]   dp_in,
   output logic [1:7]        y,
   output logic              dp,
   output logic [NDIG-1:0]   an
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [PW-1:0] CNT_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

   logic [PW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [NDIG-1:0][3:0]    sx_q, sx_d;
   logic [NDIG-1:0]         sdp_q, sdp_d;
   logic [1:7]              y_q, y_d;
   logic                    dp_q, dp_d;
   logic [NDIG-1:0]         an_q, an_d;

   logic                    tick;
   logic [3:0]              dig_sel;
   logic                    dp_sel;
   logic                    blank;

   function automatic logic [1:7] seg_decode(input logic [3:0] d);
      logic [1:7] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000001;
      endcase
      return s;
   endfunction

   assign tick = (cnt_q == CNT_MAX);

   // Prescaler, scan index and the once-per-frame snapshot (captured as idx wraps to 0).
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      sx_d  = sx_q;
      sdp_d = sdp_q;
      if (tick) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
         if (idx_q == IDX_MAX) begin
            sx_d  = x;
            sdp_d = dp_in;
         end
      end
   end

   always_comb begin
      dig_sel = '0;
      dp_sel  = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_q == IW'(i)) begin
            dig_sel = sx_q[i];
            dp_sel  = sdp_q[i];
         end
      end
   end

`ifdef BCD7_SCAN_LZB_EN
   // Blank digit idx>0 when it and every more significant shadow digit is zero.
   always_comb begin
      blank = (idx_q != '0);
      for (int j = 0; j < NDIG; j++) begin
         if ((IW'(j) >= idx_q) && (sx_q[j] != 4'd0)) blank = 1'b0;
      end
   end
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      an_d = '0;
      y_d  = '0;
      dp_d = 1'b0;
      if (e) begin
         for (int i = 0; i < NDIG; i++) an_d[i] = (idx_q == IW'(i));
         y_d  = blank ? 7'b0000000 : seg_decode(dig_sel);
         dp_d = dp_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= '0;
         sx_q  <= '0;
         sdp_q <= '0;
         y_q   <= '0;
         dp_q  <= 1'b0;
         an_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         sx_q  <= sx_d;
         sdp_q <= sdp_d;
         y_q   <= y_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign y  = y_q;
   assign dp = dp_q;
   assign an = an_q;

endmodule

// File: tb/tb_bcd7_scan.sv
// Self-checking bench for bcd7_scan: NDIG=4/SCAN_DIV=4 instance plus NDIG=1/SCAN_DIV=1 instance.
`timescale 1ns/1ps

module tb_bcd7_scan;

   localparam int N0 = 4;
   localparam int S0 = 4;

   typedef struct {
      logic [3:0] an;
      logic [6:0] y;
      logic       dp;
   } vec_t;

   logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
                                7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

`ifdef BCD7_SCAN_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk, rst_n;
   logic        e0, e1;
   logic [15:0] x0;
   logic [3:0]  dpi0;
   logic [1:7]  y0;
   logic        dp0;
   logic [3:0]  an0;
   logic [3:0]  x1;
   logic [0:0]  dpi1;
   logic [1:7]  y1;
   logic        dp1;
   logic [0:0]  an1;

   int n_chk  = 0;
   int n_fail = 0;

   bcd7_scan #(.NDIG(N0), .SCAN_DIV(S0)) dut0 (
      .clk(clk), .rst_n(rst_n), .e(e0), .x(x0), .dp_in(dpi0),
      .y(y0), .dp(dp0), .an(an0));

   bcd7_scan #(.NDIG(1), .SCAN_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .e(e1), .x(x1), .dp_in(dpi1),
      .y(y1), .dp(dp1), .an(an1));

   always #5 clk = ~clk;

   // Reference for dut0: edge count k since reset gives slot = k/S0, digit = slot%N0,
   // and a new snapshot lands whenever k is a multiple of a whole frame.
   int         k0;
   int         m_idx;
   bit         m_blank;
   logic [3:0] sh0 [N0];
   logic [3:0] sdp0;
   logic [6:0] m_y;
   logic [3:0] m_an;
   logic       m_dp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k0 = 0;
         for (int i = 0; i < N0; i++) sh0[i] = 4'd0;
         sdp0 = 4'd0;
         m_y = 7'd0; m_an = 4'd0; m_dp = 1'b0;
      end else begin
         m_idx   = (k0 / S0) % N0;
         m_blank = 1'b0;
         if (LZB && m_idx > 0) begin
            m_blank = 1'b1;
            for (int j = 0; j < N0; j++)
               if (j >= m_idx && sh0[j] != 4'd0) m_blank = 1'b0;
         end
         m_an = e0 ? 4'(1 << m_idx) : 4'd0;
         m_y  = (e0 && !m_blank) ? seg_tab[sh0[m_idx]] : 7'd0;
         m_dp = e0 && sdp0[m_idx];
         k0++;
         if (k0 % (S0 * N0) == 0) begin
            for (int i = 0; i < N0; i++) sh0[i] = x0[4*i +: 4];
            sdp0 = dpi0;
         end
      end
   end

   // Reference for dut1: output shows the input applied two edges earlier.
   logic [3:0] q1x [$];
   logic       q1d [$];
   logic [6:0] m1_y;
   logic       m1_an;
   logic       m1_dp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1x.delete(); q1d.delete();
         m1_y = 7'd0; m1_an = 1'b0; m1_dp = 1'b0;
      end else begin
         m1_an = 1'b1;
         if (q1x.size() > 0) begin
            m1_y  = seg_tab[q1x[$]];
            m1_dp = q1d[$];
         end else begin
            m1_y  = seg_tab[0];
            m1_dp = 1'b0;
         end
         q1x.push_back(x1);
         q1d.push_back(dpi1[0]);
         if (q1x.size() > 4) begin
            void'(q1x.pop_front());
            void'(q1d.pop_front());
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      chk("model0", 32'({y0, an0, dp0}), 32'({m_y, m_an, m_dp}));
      chk("model1", 32'({y1, an1, dp1}), 32'({m1_y, m1_an, m1_dp}));
      x1   = 4'($urandom);
      dpi1 = 1'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t       tab [4];
      logic [6:0] exp_y;
      int         d;

      tab[0] = '{4'b0001, 7'b0110011, 1'b0};
      tab[1] = '{4'b0010, 7'b1111001, 1'b0};
      tab[2] = '{4'b0100, 7'b1101101, 1'b1};
      tab[3] = '{4'b1000, 7'b0110000, 1'b0};

      clk = 1'b0; rst_n = 1'b0; e0 = 1'b0; e1 = 1'b1;
      x0 = 16'h0; dpi0 = 4'h0; x1 = 4'h0; dpi1 = 1'b0;
      #1;
      chk("rst_outs", 32'({y0, an0, dp0}), 32'd0);
      repeat (3) step();

      // Release, then run two frames of 1234 with dp on digit 2.
      rst_n = 1'b1; e0 = 1'b1; x0 = 16'h1234; dpi0 = 4'b0100;
      step();
      chk("rst_an_first", 32'(an0), 32'b0001);
      repeat (3) begin
         step();
         chk("slot0_hold", 32'(an0), 32'b0001);
      end
      step();
      chk("slot1_start", 32'(an0), 32'b0010);
      repeat (11) step();
      for (int j = 0; j < 16; j++) begin
         step();
         chk("scan_an", 32'(an0), 32'(tab[j/4].an));
         chk("scan_y",  32'(y0),  32'(tab[j/4].y));
         chk("scan_dp", 32'(dp0), 32'(tab[j/4].dp));
         if (j == 8) x0 = 16'h9999;
      end
      step();
      chk("notear_d0", 32'(y0), 32'b1111011);

      // Invalid codes and enable gap.
      x0 = 16'hFA00;
      repeat (15) step();
      repeat (8) step();
      step();
      chk("dash_d2", 32'({an0, y0}), 32'({4'b0100, 7'b0000001}));
      repeat (3) step();
      step();
      chk("dash_d3", 32'({an0, y0}), 32'({4'b1000, 7'b0000001}));
      step();
      e0 = 1'b0;
      step();
      chk("dis_outs", 32'({y0, an0, dp0}), 32'd0);
      step();
      step();
      chk("dis_an", 32'(an0), 32'd0);
      e0 = 1'b1;
      step();
      chk("resume_an", 32'(an0), 32'b0001);
      chk("resume_y",  32'(y0),  32'b1111110);

      // Leading zeros: 0050 then 0000.
      x0 = 16'h0050; dpi0 = 4'h0;
      repeat (14) step();
      for (int j = 0; j < 32; j++) begin
         step();
         if (j == 0) x0 = 16'h0000;
         d = j / 4 % 4;
         if (j < 16)
            exp_y = (d == 0) ? 7'b1111110 : (d == 1) ? 7'b1011011 :
                    (LZB ? 7'b0 : 7'b1111110);
         else
            exp_y = (d == 0 || !LZB) ? 7'b1111110 : 7'b0;
         chk("lzb_an", 32'(an0), 32'(1 << d));
         chk("lzb_y",  32'(y0),  32'(exp_y));
      end

      // Randomized run against the reference model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0) x0 = 16'($urandom);
         dpi0 = 4'($urandom);
         e0   = ($urandom_range(0, 9) != 0);
         step();
      end

      // Reset mid-count: outputs clear without a clock edge, frame restarts showing zeros.
      e0 = 1'b1; x0 = 16'h1234; dpi0 = 4'h0;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_outs0", 32'({y0, an0, dp0}), 32'd0);
      chk("midrst_outs1", 32'({y1, an1, dp1}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         d = (k - 1) / 4;
         chk("midrst_an", 32'(an0), 32'(1 << d));
         chk("midrst_y",  32'(y0),  32'((d == 0 || !LZB) ? 7'b1111110 : 7'b0));
      end
      step();
      chk("midrst_snap", 32'(y0), 32'b0110011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
